// File: rtl/demorgan_pkg.sv
// Shared definitions for the De Morgan sweep block.
// Contents:
//   state_t      - sweep FSM states (IDLE, DRIVE, SAMPLE, DONE)
//   NUM_VECTORS  - number of {a,b} input combinations swept
//   ERR_W        - width of err_count (holds 0..NUM_VECTORS)
//   SETTLE_W     - width of the settle counter (SETTLE_CYCLES is 0..15)
//   IDX_W        - width of the vector index
package demorgan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 4;
  localparam int ERR_W       = 3;
  localparam int SETTLE_W    = 4;
  localparam int IDX_W       = 2;

endpackage

// File: rtl/demorgan_golden.sv
// Combinational checker for one De Morgan vector.
// Computes the golden value of each gate stage from a/b and flags the
// vector when either law pair disagrees or any stage differs from golden.
// Ports:
//   a, b        - stimulus bits currently applied
//   nandnb_in   - observed ~a & ~b
//   naorb_in    - observed ~(a | b)
//   nanb_or_in  - observed ~a | ~b
//   naandb_in   - observed ~(a & b)
//   fail        - 1 when this vector is wrong
module demorgan_golden (
  input  logic a,
  input  logic b,
  input  logic nandnb_in,
  input  logic naorb_in,
  input  logic nanb_or_in,
  input  logic naandb_in,
  output logic fail
);

  logic gold_nandnb;
  logic gold_naorb;
  logic gold_nanb_or;
  logic gold_naandb;
  logic law_fail;
  logic gold_fail;

  assign gold_nandnb  = ~a & ~b;
  assign gold_naorb   = ~(a | b);
  assign gold_nanb_or = ~a | ~b;
  assign gold_naandb  = ~(a & b);

  // The two law pairs must agree with each other as well as with golden.
  assign law_fail  = (nandnb_in != naorb_in) | (nanb_or_in != naandb_in);
  assign gold_fail = (nandnb_in  != gold_nandnb)  | (naorb_in  != gold_naorb) |
                     (nanb_or_in != gold_nanb_or) | (naandb_in != gold_naandb);

  assign fail = law_fail | gold_fail;

endmodule

// File: rtl/demorgan_sweep.sv
// Exhaustive De Morgan sweep controller.
// On start (sampled in IDLE) it drives {a,b} = 00,01,10,11, holds each
// vector SETTLE_CYCLES cycles, samples the four observed gate outputs for
// one cycle, and records failures. A one-cycle DONE publishes the result.
// Ports:
//   clk, rst_n           - clock and synchronous active-low reset
//   start                - launch a sweep (level-sampled in IDLE)
//   a, b                 - registered stimulus to the gate stages
//   nandnb_in..naandb_in - observed gate stage outputs
//   busy                 - high in DRIVE and SAMPLE
//   done                 - one-cycle pulse in DONE
//   pass                 - last sweep had no failing vector
//   err_count            - failing vectors in last sweep (saturates at 4)
//   fail_vec             - bit i set when vector i failed
//   fsm_state            - current FSM state, for observation
module demorgan_sweep
  import demorgan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   a,
  output logic                   b,
  input  logic                   nandnb_in,
  input  logic                   naorb_in,
  input  logic                   nanb_or_in,
  input  logic                   naandb_in,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_W-1:0]       err_count,
  output logic [NUM_VECTORS-1:0] fail_vec,
  output state_t                 fsm_state
);

  // Last settle count value; only meaningful when SETTLE_CYCLES > 0.
  localparam int                   SETTLE_LAST_I = (SETTLE_CYCLES == 0) ? 0 : int'(SETTLE_CYCLES) - 1;
  localparam logic [SETTLE_W-1:0]  SETTLE_LAST   = SETTLE_W'(SETTLE_LAST_I);
  localparam logic [IDX_W-1:0]     LAST_IDX      = IDX_W'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0]     ERR_MAX       = ERR_W'(NUM_VECTORS);
  // With no settle time a new vector goes straight to sampling.
  localparam state_t               VEC_ENTRY     = (SETTLE_CYCLES == 0) ? SAMPLE : DRIVE;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                vec_fail;
  logic [ERR_W-1:0]    err_sat;

  demorgan_golden u_golden (
    .a          (a),
    .b          (b),
    .nandnb_in  (nandnb_in),
    .naorb_in   (naorb_in),
    .nanb_or_in (nanb_or_in),
    .naandb_in  (naandb_in),
    .fail       (vec_fail)
  );

  assign err_sat   = (err_count == ERR_MAX) ? err_count : err_count + 1'b1;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= VEC_ENTRY;
            idx        <= '0;
            settle_cnt <= '0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b1;
            err_count  <= '0;
            fail_vec   <= '0;
            pass       <= 1'b0;
          end
        end
        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state      <= SAMPLE;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          if (vec_fail) begin
            fail_vec[idx] <= 1'b1;
            err_count     <= err_sat;
          end
          if (idx == LAST_IDX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            a     <= 1'b0;
            b     <= 1'b0;
            // Fold in the final vector so pass is valid alongside done.
            pass  <= (err_count == '0) && !vec_fail;
          end else begin
            state    <= VEC_ENTRY;
            idx      <= idx + 1'b1;
            {a, b}   <= idx + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demorgan_sweep.sv
module tb_demorgan_sweep;
  import demorgan_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  logic start;
  always #5 clk = ~clk;

  // DUT with SETTLE_CYCLES=2 and its gate-stage environment
  logic a, b, busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  state_t fsm_state;
  logic nandnb_in, naorb_in, nanb_or_in, naandb_in;
  int fault; // 0 correct, 1 nanb_or stuck at 0, 2 nandnb inverted

  assign nandnb_in  = (fault == 2) ? (a | b) : (~a & ~b);
  assign naorb_in   = ~(a | b);
  assign nanb_or_in = (fault == 1) ? 1'b0 : (~a | ~b);
  assign naandb_in  = ~(a & b);

  demorgan_sweep #(.SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .nandnb_in(nandnb_in), .naorb_in(naorb_in), .nanb_or_in(nanb_or_in),
    .naandb_in(naandb_in), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec), .fsm_state(fsm_state)
  );

  // DUT with SETTLE_CYCLES=0, always correct stages
  logic a0, b0, busy0, done0, pass0;
  logic [2:0] err_count0;
  logic [3:0] fail_vec0;
  state_t fsm_state0;

  demorgan_sweep #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a0), .b(b0),
    .nandnb_in(~a0 & ~b0), .naorb_in(~(a0 | b0)), .nanb_or_in(~a0 | ~b0),
    .naandb_in(~(a0 & b0)), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err_count0), .fail_vec(fail_vec0), .fsm_state(fsm_state0)
  );

  // Scoreboard counters
  int n_vec = 0;
  int n_err = 0;

  task check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Per-sweep observations
  int done_cyc, busy_cyc, ab_bad, done0_cyc, done_cnt;
  logic [3:0] fv_d;
  logic [2:0] ec_d;
  logic ps_d, ps0_d;

  // Pulse start for one cycle, then watch 30 cycles (sampled on negedge).
  // Cycle k=1 is the first cycle after the edge that accepts start.
  // poke: pulse start again while busy, which must be ignored.
  task run_sweep(input bit poke);
    done_cyc = 0; busy_cyc = 0; ab_bad = 0; done0_cyc = 0; done_cnt = 0;
    fv_d = 'x; ec_d = 'x; ps_d = 'x; ps0_d = 'x;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (busy) begin
        busy_cyc++;
        if ({a, b} != 2'((k - 1) / 3)) ab_bad++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = k; fv_d = fail_vec; ec_d = err_count; ps_d = pass;
        end
      end
      if (done0 && done0_cyc == 0) begin
        done0_cyc = k; ps0_d = pass0;
      end
      if (poke && k == 5) start = 1'b1;
      if (poke && k == 6) start = 1'b0;
      @(negedge clk);
    end
  endtask

  task check_sweep(input string tag, input logic [3:0] fv, input logic [2:0] ec, input logic ps);
    check({tag, "_done_cyc"}, 8'(done_cyc), 8'd13);
    check({tag, "_busy_cyc"}, 8'(busy_cyc), 8'd12);
    check({tag, "_done_cnt"}, 8'(done_cnt), 8'd1);
    check({tag, "_ab_order"}, 8'(ab_bad), 8'd0);
    check({tag, "_fail_vec"}, 8'(fv_d), 8'(fv));
    check({tag, "_err_count"}, 8'(ec_d), 8'(ec));
    check({tag, "_pass"}, 8'(ps_d), 8'(ps));
  endtask

  int nd;

  initial begin
    rst_n = 1'b0; start = 1'b0; fault = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_done", 8'(done), 8'd0);
    check("rst_pass", 8'(pass), 8'd0);
    check("rst_err", 8'(err_count), 8'd0);
    check("rst_fv", 8'(fail_vec), 8'd0);
    check("rst_ab", 8'({a, b}), 8'd0);
    check("rst_state", 8'(fsm_state), 8'(IDLE));
    rst_n = 1'b1;

    // Clean sweep, with a start pulse while busy; also SETTLE_CYCLES=0 instance
    run_sweep(1'b1);
    check_sweep("clean", 4'b0000, 3'd0, 1'b1);
    check("s0_done_cyc", 8'(done0_cyc), 8'd5);
    check("s0_pass", 8'(ps0_d), 8'd1);
    check("hold_pass", 8'(pass), 8'd1);
    check("idle_ab", 8'({a, b}), 8'd0);

    fault = 1;
    run_sweep(1'b0);
    check_sweep("stuck", 4'b0111, 3'd3, 1'b0);
    check("stuck_hold_fv", 8'(fail_vec), 8'b0111);

    fault = 2;
    run_sweep(1'b0);
    check_sweep("inv", 4'b1111, 3'd4, 1'b0);

    // Reset during vector 2
    fault = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_ab_vec2", 8'({a, b}), 8'b10);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("mid_state", 8'(fsm_state), 8'(IDLE));
    check("mid_busy", 8'(busy), 8'd0);
    check("mid_ab", 8'({a, b}), 8'd0);
    check("mid_err", 8'(err_count), 8'd0);
    check("mid_fv", 8'(fail_vec), 8'd0);
    check("mid_pass", 8'(pass), 8'd0);
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) nd++;
      @(negedge clk);
    end
    check("mid_no_done", 8'(nd), 8'd0);
    run_sweep(1'b0);
    check_sweep("post_rst", 4'b0000, 3'd0, 1'b1);

    // Start held high: back-to-back sweeps, results cleared on re-accept
    fault = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 20 && !done; k++) @(negedge clk);
    check("held_done", 8'(done), 8'd1);
    check("held_fv1", 8'(fail_vec), 8'b0111);
    @(negedge clk);
    check("held_idle_busy", 8'(busy), 8'd0);
    check("held_idle_fv", 8'(fail_vec), 8'b0111);
    check("held_idle_err", 8'(err_count), 8'd3);
    fault = 0;
    @(negedge clk);
    check("held_busy2", 8'(busy), 8'd1);
    check("held_clr_fv", 8'(fail_vec), 8'd0);
    check("held_clr_err", 8'(err_count), 8'd0);
    check("held_clr_pass", 8'(pass), 8'd0);
    start = 1'b0;
    for (int k = 0; k < 20 && !done; k++) @(negedge clk);
    check("held_done2", 8'(done), 8'd1);
    check("held_pass2", 8'(pass), 8'd1);
    check("held_fv2", 8'(fail_vec), 8'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demorgan_sweep.md
DEMORGAN_SWEEP -- requirements
Module: demorgan_sweep

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, is the number of cycles each input vector is held before sampling; legal range is 0..15.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to run one exhaustive sweep; sampled only in IDLE.
REQ-005 a  output  1  stimulus bit A driven into the De Morgan gate stages.
REQ-006 b  output  1  stimulus bit B driven into the De Morgan gate stages.
REQ-007 nandnb_in  input  1  observed ~A&~B from the AND-of-inverted-inputs stage.
REQ-008 naorb_in  input  1  observed ~(A|B) from the negated-OR stage.
REQ-009 nanb_or_in  input  1  observed ~A|~B from the OR-of-inverted-inputs stage.
REQ-010 naandb_in  input  1  observed ~(A&B) from the negated-AND stage.
REQ-011 busy  output  1  high while a sweep is in progress.
REQ-012 done  output  1  single-cycle pulse marking sweep completion.
REQ-013 pass  output  1  high when the last completed sweep had zero failing vectors.
REQ-014 err_count  output  3  number of failing vectors in the last sweep, 0..4.
REQ-015 fail_vec  output  4  bit i is set when vector i ({a,b}=i) failed.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, DRIVE, SAMPLE, DONE.
REQ-017 IDLE with start=1 SHALL go to DRIVE, set vector index 0, clear err_count and fail_vec, and deassert pass, all on that edge.
REQ-018 DRIVE SHALL last SETTLE_CYCLES cycles and then go to SAMPLE; with SETTLE_CYCLES=0, IDLE and next-vector transitions SHALL go directly to SAMPLE.
REQ-019 SAMPLE SHALL last one cycle and compare the four observed inputs at the end of that cycle.
REQ-020 A vector SHALL fail when nandnb_in!=naorb_in, when nanb_or_in!=naandb_in, or when any observed input differs from its golden value computed from a and b.
REQ-021 On a failing SAMPLE, fail_vec[index] SHALL be set and err_count SHALL increment; err_count SHALL saturate at 4.
REQ-022 After SAMPLE, index<3 SHALL increment the index and go to DRIVE (or SAMPLE when SETTLE_CYCLES=0); index==3 SHALL go to DONE.
REQ-023 Vector order SHALL be {a,b}=00,01,10,11; a and b SHALL be constant for the whole of each vector's DRIVE+SAMPLE window.
REQ-024 DONE SHALL last one cycle with done=1 and busy=0, set pass=(err_count==0 including the final vector), and return to IDLE.
REQ-025 busy SHALL be 1 in DRIVE and SAMPLE, and 0 in IDLE and DONE.
REQ-026 Sweep latency: done SHALL assert 4*(SETTLE_CYCLES+1)+1 cycles after the edge that samples start.
REQ-027 start SHALL be ignored in DRIVE, SAMPLE and DONE; it is level-sampled in IDLE, so start held high SHALL launch back-to-back sweeps.
REQ-028 pass, err_count and fail_vec SHALL hold their values from DONE until the next accepted start.
REQ-029 In IDLE and DONE, a and b SHALL be 0.

Reset
REQ-030 rst_n=0 at a rising clk edge SHALL force IDLE and a=b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, index=0, and clear the settle counter.
REQ-031 Reset mid-sweep SHALL abandon the sweep with no done pulse; partial results SHALL be discarded.
REQ-032 Outputs SHALL have no asynchronous dependency on rst_n.

Structure
REQ-033 The package demorgan_pkg SHALL hold the state enum, the constant NUM_VECTORS=4, and the widths of err_count and the settle counter.
REQ-034 Golden-value computation and the law comparison SHALL live in one combinational sub-module, demorgan_golden (inputs a, b, four observed bits; output fail).

Verification
REQ-035 Correct gate stages, SETTLE_CYCLES=2, start pulse -> busy for 12 cycles, done on cycle 13, pass=1, err_count=0, fail_vec=4'b0000.
REQ-036 nanb_or_in stuck at 0 -> fail_vec=4'b0111, err_count=3, pass=0.
REQ-037 nandnb_in inverted -> fail_vec=4'b1111, err_count=4, pass=0.
REQ-038 rst_n low for one cycle during vector 2 -> IDLE on next cycle, all outputs 0, no done pulse; a following start -> a full clean sweep.
REQ-039 start pulsed during busy -> no effect; start held high -> a second sweep begins the cycle after DONE and clears the previous results.
REQ-040 SETTLE_CYCLES=0, correct stages -> done on cycle 5 after start, pass=1.
